// File: rtl/even_parity_checker.sv
// rtl/even_parity_checker.sv - even-parity serial frame receiver (start, data LSB first, parity, stop)
// Optional saturating parity-error counter enabled by `define PARITY_ERR_CNT_EN.
module even_parity_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
`ifdef PARITY_ERR_CNT_EN
    output logic [CNT_W-1:0]  err_cnt,
`endif
    output logic              busy
);

    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
        $error("even_parity_checker: DATA_W and CNT_W must be >= 1");
    end

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] shift_next;

    // New bit enters at the MSB so the first data bit ends up in bit 0.
    if (DATA_W == 1) begin : g_shift_one
        assign shift_next = in_bit;
    end else begin : g_shift_many
        assign shift_next = {in_bit, shift_q[DATA_W-1:1]};
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!in_bit) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        acc_d     = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d   = shift_next;
                    acc_d     = acc_q ^ in_bit;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    acc_d   = acc_q ^ in_bit;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (in_bit) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        parity_err_d = acc_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    // Saturates at all-ones; only accepted frames with bad parity count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (data_valid_d && parity_err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_even_parity_checker.sv
// tb/tb_even_parity_checker.sv - directed and random frame checks for even_parity_checker
module tb_even_parity_checker;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_bit;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0]  err_cnt;
`endif

    even_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
`ifdef PARITY_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    logic [DATA_W-1:0] exp_data;
    int  exp_cnt;
    bit  stall_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (stall_en) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom));
        end
        step(1'b1, b);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef PARITY_ERR_CNT_EN
        chk({tag, ".err_cnt"}, 32'(err_cnt), exp_cnt);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // Reference: parity error whenever data plus parity holds an odd number of ones.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic stop_b,
                              input int stall_at, input string tag);
        logic exp_pe;
        send_bit(1'b0);
        chk({tag, ".busy_start"}, 32'(busy), 32'd1);
        chk({tag, ".pulse_clear"}, 32'({data_valid, frame_err}), 32'd0);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == stall_at) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b1);
            end
            send_bit(d[i]);
        end
        send_bit(p);
        send_bit(stop_b);
        if (stop_b) begin
            exp_pe   = (($countones(d) + int'(p)) % 2) != 0;
            exp_data = d;
            if (exp_pe && exp_cnt < CNT_MAX) exp_cnt++;
            chk({tag, ".data_valid"}, 32'(data_valid), 32'd1);
            chk({tag, ".parity_err"}, 32'(parity_err), 32'(exp_pe));
            chk({tag, ".frame_err"}, 32'(frame_err), 32'd0);
        end else begin
            chk({tag, ".frame_err"}, 32'(frame_err), 32'd1);
            chk({tag, ".data_valid"}, 32'(data_valid), 32'd0);
            chk({tag, ".parity_err"}, 32'(parity_err), 32'd0);
        end
        chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk_cnt(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        exp_data = '0;
        exp_cnt  = 0;
        stall_en = 1'b0;

        rst = 1'b1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("reset.outputs", 32'({data_out, data_valid, parity_err, frame_err, busy}), 32'd0);
        chk_cnt("reset");
        rst = 1'b0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("idle.busy", 32'(busy), 32'd0);

        send_frame(3'b011, 1'b0, 1'b1, -1, "clean");
        send_frame(3'b001, 1'b0, 1'b1, -1, "perr");
        send_frame(3'b111, 1'b1, 1'b0, -1, "ferr");
        step(1'b1, 1'b1);
        chk("ferr.pulse_len", 32'({data_valid, frame_err}), 32'd0);

        send_frame(3'b101, 1'b0, 1'b1, 1, "stall");
        send_frame(3'b111, 1'b1, 1'b1, -1, "b2b");

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        chk("midrst.outputs", 32'({data_out, data_valid, parity_err, frame_err, busy}), 32'd0);
        exp_data = '0;
        exp_cnt  = 0;
        chk_cnt("midrst");
        rst = 1'b0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("midrst.no_pulse", 32'({data_valid, frame_err, busy}), 32'd0);
        send_frame(3'b010, 1'b1, 1'b1, -1, "post_rst");

        for (int v = 0; v < 8; v++) begin
            d = DATA_W'(v);
            send_frame(d, ($countones(d) % 2) != 0, 1'b1, -1, "exh_good");
        end
        for (int v = 0; v < 8; v++) begin
            d = DATA_W'(v);
            send_frame(d, ($countones(d) % 2) == 0, 1'b1, -1, "exh_bad");
        end

        stall_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b1);
            send_frame(DATA_W'($urandom), 1'($urandom), $urandom_range(0, 7) != 0,
                       -1, "rand");
        end
        stall_en = 1'b0;

        for (int n = 0; n < 10; n++) begin
            send_frame(3'b000, 1'b1, 1'b1, -1, "sat");
        end

        step(1'b1, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
